// File: rtl/popcount_stream_if.sv
// Stream bundle for popcount_stream.
// Carries the word-in handshake (with its data and mode) and the result-out handshake.
// "slave" is the counter's view. "master" is the view of whatever feeds words and takes results.
interface popcount_stream_if #(
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;

    modport slave (
        input  in_valid,
        input  in_data,
        input  mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_count
    );

    modport master (
        output in_valid,
        output in_data,
        output mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_count
    );
endinterface

// File: rtl/popcount_stream.sv
// Streaming population counter.
// An accepted word is counted CHUNK bits per clock. The result is then offered on a
// valid/ready output. Every delivered count feeds a saturating running total.
// mode=1 counts zeros: the word is inverted when it is captured.
module popcount_stream #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int ACC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    popcount_stream_if.slave   strm,
    input  logic               acc_clr,
    output logic [ACC_W-1:0]   acc_total,
    output logic               acc_sat,
    output logic               busy
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int PW  = $clog2(CHUNK + 1);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    // The sum is one bit wider than the accumulator, so the clamp can see the overflow.
    // It also never truncates a count that is wider than the accumulator.
    localparam int SW  = ((CW > ACC_W) ? CW : ACC_W) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    part_q;
    logic [CW-1:0]    count_q;
    logic [ACC_W-1:0] acc_q;
    logic             sat_q;

    logic [CHUNK-1:0] chunk_w [NCH];
    logic [CHUNK-1:0] cur_chunk;
    logic [PW-1:0]    chunk_pop;
    logic [CW-1:0]    part_d;
    logic [IW-1:0]    idx_d;
    logic [ACC_W-1:0] acc_d;
    logic             sat_d;
    logic [ACC_W-1:0] acc_base;
    logic [SW-1:0]    acc_sum;
    logic             in_hs;
    logic             out_hs;

    // Split the captured word into its chunks. Chunk 0 is the least significant one.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
        assign chunk_w[gi] = data_q[gi*CHUNK +: CHUNK];
    end

    assign strm.in_ready  = (state_q == S_IDLE);
    assign strm.out_valid = (state_q == S_DONE);
    assign strm.out_count = count_q;
    assign acc_total      = acc_q;
    assign acc_sat        = sat_q;
    assign busy           = (state_q != S_IDLE);

    assign in_hs  = strm.in_valid && (state_q == S_IDLE);
    assign out_hs = strm.out_ready && (state_q == S_DONE);

    // Select the current chunk, count its ones and form the next partial sum and index.
    always_comb begin
        cur_chunk = '0;
        for (int i = 0; i < NCH; i++) begin
            if (idx_q == IW'(i)) begin
                cur_chunk = chunk_w[i];
            end
        end
        chunk_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_pop = chunk_pop + PW'(cur_chunk[i]);
        end
        part_d = part_q + CW'(chunk_pop);
        idx_d  = (idx_q == IW'(NCH - 1)) ? '0 : idx_q + 1'b1;
    end

    // Accumulator next state. A clear that arrives with a handshake empties the total first,
    // then the delivered count is added and the sum is clamped.
    always_comb begin
        acc_d    = acc_q;
        sat_d    = sat_q;
        acc_base = acc_clr ? '0 : acc_q;
        acc_sum  = SW'(acc_base) + SW'(count_q);
        if (out_hs) begin
            if (acc_sum > SW'(ACC_MAX)) begin
                acc_d = ACC_MAX;
                sat_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
                sat_d = acc_clr ? 1'b0 : sat_q;
            end
        end else if (acc_clr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end
    end

    // Control FSM: capture a word, count it chunk by chunk, then hold the result until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            part_q  <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_hs) begin
                        data_q  <= strm.mode ? ~strm.in_data : strm.in_data;
                        part_q  <= '0;
                        idx_q   <= '0;
                        state_q <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    part_q <= part_d;
                    idx_q  <= idx_d;
                    if (idx_q == IW'(NCH - 1)) begin
                        count_q <= part_d;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_hs) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Running total of delivered counts with a sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end
endmodule
